// File: rtl/cordic_arb_pkg.sv
// Shared types and the round-robin pick helper
// for the CORDIC request arbiter.
package cordic_arb_pkg;

  localparam int N_REQ_MAX = 8;
  localparam int ANGLE_W   = 32;
  localparam int OUT_W     = 32;

  typedef logic [$clog2(N_REQ_MAX)-1:0] req_idx_t;
  typedef logic [N_REQ_MAX-1:0]         req_vec_t;

  // First set bit at or after ptr, wrapping within n.
  function automatic req_vec_t rr_pick(
    input req_vec_t valid,
    input req_idx_t ptr,
    input int       n
  );
    req_vec_t g;
    req_idx_t idx;
    logic     found;
    int       s;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ_MAX; i++) begin
      s   = int'((32'(ptr) + 32'(i)) % 32'(n));
      idx = req_idx_t'(s);
      if (i < n && !found && valid[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/cordic_req_arbiter_tag_fifo.sv
// In-order tag FIFO: remembers which requester
// issued each angle still inside the CORDIC.
module cordic_tag_fifo
  import cordic_arb_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic                   pop,
  input  req_idx_t               din,
  output req_idx_t               dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  req_idx_t      mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    full    = (cnt_q == (AW+1)'(DEPTH));
    empty   = (cnt_q == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/cordic_req_arbiter.sv
// Round-robin sharing of one pipelined CORDIC
// core, with per-issue tags routing results back.
module cordic_req_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ANGLE_W   = 32,
  parameter int OUT_W     = 32,
  parameter int TAG_DEPTH = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*ANGLE_W-1:0] req_angle,
  output logic [N_REQ-1:0]         req_ready,
  output logic [ANGLE_W-1:0]       cordic_din_a,
  output logic                     cordic_din_valid,
  input  logic                     cordic_rfd,
  input  logic                     cordic_dout_valid,
  input  logic [OUT_W-1:0]         cordic_dout_x,
  input  logic [OUT_W-1:0]         cordic_dout_y,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [OUT_W-1:0]         rsp_cos,
  output logic [OUT_W-1:0]         rsp_sin,
  output logic [$clog2(TAG_DEPTH):0] outstanding,
  output logic                     err_orphan
);

  req_vec_t           pick, grant_full;
  logic [N_REQ-1:0]   grant;
  req_idx_t           g_idx;
  logic               can_issue, xfer, pop;
  logic               tag_full, tag_empty;
  req_idx_t           tag_dout;

  logic [ANGLE_W-1:0] din_a_q, din_a_d;
  logic               din_valid_q, din_valid_d;
  req_idx_t           rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [OUT_W-1:0]   rsp_cos_q, rsp_cos_d;
  logic [OUT_W-1:0]   rsp_sin_q, rsp_sin_d;
  logic               err_q, err_d;

  // tag_full is registered, so a pop never frees a slot same-cycle
  always_comb begin
    can_issue  = cordic_rfd & ~tag_full & ~RST;
    pick       = rr_pick(req_vec_t'(req_valid),
                         rr_ptr_q, N_REQ);
    grant_full = can_issue ? pick : '0;
    xfer       = |grant_full;
    g_idx      = '0;
    for (int i = 0; i < N_REQ_MAX; i++)
      if (grant_full[i]) g_idx = req_idx_t'(i);
    grant      = grant_full[N_REQ-1:0];
  end

  always_comb begin
    din_a_d = din_a_q;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i])
        din_a_d = req_angle[i*ANGLE_W +: ANGLE_W];
    din_valid_d = xfer;
    rr_ptr_d    = rr_ptr_q;
    if (xfer)
      rr_ptr_d = (g_idx == req_idx_t'(N_REQ-1)) ?
                 '0 : g_idx + 1'b1;
  end

  always_comb begin
    pop = cordic_dout_valid & ~tag_empty;
    for (int i = 0; i < N_REQ; i++)
      rsp_valid_d[i] = pop &
                       (tag_dout == req_idx_t'(i));
    rsp_cos_d = pop ? cordic_dout_x : rsp_cos_q;
    rsp_sin_d = pop ? cordic_dout_y : rsp_sin_q;
    err_d     = err_q |
                (cordic_dout_valid & tag_empty);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      din_a_q     <= '0;
      din_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_cos_q   <= '0;
      rsp_sin_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      din_a_q     <= din_a_d;
      din_valid_q <= din_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_cos_q   <= rsp_cos_d;
      rsp_sin_q   <= rsp_sin_d;
      err_q       <= err_d;
    end
  end

  cordic_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (xfer),
    .pop   (pop),
    .din   (g_idx),
    .dout  (tag_dout),
    .full  (tag_full),
    .empty (tag_empty),
    .count (outstanding)
  );

  assign req_ready        = grant;
  assign cordic_din_a     = din_a_q;
  assign cordic_din_valid = din_valid_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_cos          = rsp_cos_q;
  assign rsp_sin          = rsp_sin_q;
  assign err_orphan       = err_q;

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Directed bench for cordic_req_arbiter with a
// fixed-latency behavioural CORDIC model.
module tb_cordic_req_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int OW = 32;
  localparam int TD = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic [NR-1:0] req_valid;
  logic [NR*AW-1:0] req_angle;
  logic [NR-1:0] req_ready;
  logic [AW-1:0] din_a;
  logic          din_valid;
  logic          rfd;
  logic          dout_valid;
  logic [OW-1:0] dout_x, dout_y;
  logic [NR-1:0] rsp_valid;
  logic [OW-1:0] rsp_cos, rsp_sin;
  logic [$clog2(TD):0] outstanding;
  logic          err_orphan;

  cordic_req_arbiter #(
    .N_REQ(NR), .ANGLE_W(AW),
    .OUT_W(OW), .TAG_DEPTH(TD)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_angle(req_angle),
    .req_ready(req_ready),
    .cordic_din_a(din_a),
    .cordic_din_valid(din_valid),
    .cordic_rfd(rfd),
    .cordic_dout_valid(dout_valid),
    .cordic_dout_x(dout_x), .cordic_dout_y(dout_y),
    .rsp_valid(rsp_valid),
    .rsp_cos(rsp_cos), .rsp_sin(rsp_sin),
    .outstanding(outstanding),
    .err_orphan(err_orphan)
  );

  always #5 CLK = ~CLK;

  // CORDIC model: latency lat, x = angle+1, y = angle+2
  int          lat;
  logic        force_dv;
  logic [63:0] vpipe;
  logic [AW-1:0] apipe [64];

  always @(posedge CLK) begin
    if (RST) vpipe <= '0;
    else     vpipe <= {vpipe[62:0], din_valid};
    apipe[0] <= din_a;
    for (int k = 1; k < 64; k++) apipe[k] <= apipe[k-1];
  end

  assign dout_valid = vpipe[lat-1] | force_dv;
  assign dout_x     = apipe[lat-1] + 32'd1;
  assign dout_y     = apipe[lat-1] + 32'd2;

  typedef struct {
    int          idx;
    logic [31:0] cos;
    logic [31:0] sin;
  } rsp_t;

  int   gq [$];
  rsp_t rq [$];
  int   viol = 0;
  logic rfd_prev = 1'b1;

  function automatic int oh_idx(input logic [NR-1:0] v);
    int r;
    r = -1;
    if ($countones(v) == 1)
      for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if ((req_valid & req_ready) != 0) begin
        gq.push_back(oh_idx(req_ready));
        if (oh_idx(req_ready) < 0) viol <= viol + 1;
      end
      if ((req_ready & ~req_valid) != 0) viol <= viol + 1;
      if (!rfd && req_ready != 0) viol <= viol + 1;
      if (!rfd && !rfd_prev && din_valid) viol <= viol + 1;
      if (outstanding > TD) viol <= viol + 1;
      if (rsp_valid != 0) begin
        rq.push_back('{oh_idx(rsp_valid), rsp_cos, rsp_sin});
        if (oh_idx(rsp_valid) < 0) viol <= viol + 1;
      end
      rfd_prev <= rfd;
    end
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_angle(input int i,
                           input logic [31:0] a);
    req_angle[i*AW +: AW] = a;
  endtask

  logic [31:0] ang [NR];
  int g0, r0, ne;

  initial begin
    RST = 1'b1; req_valid = '0; req_angle = '0;
    rfd = 1'b1; force_dv = 1'b0; lat = 20;
    for (int i = 0; i < NR; i++)
      ang[i] = 32'h1000_0000 * (i + 1);
    repeat (3) tick();
    chk("rst_ready", 64'(req_ready), 0);
    chk("rst_dvalid", 64'(din_valid), 0);
    chk("rst_rspv", 64'(rsp_valid), 0);
    chk("rst_outst", 64'(outstanding), 0);
    chk("rst_err", 64'(err_orphan), 0);
    chk("rst_din_a", 64'(din_a), 0);
    chk("rst_cos", 64'(rsp_cos), 0);
    chk("rst_sin", 64'(rsp_sin), 0);
    RST = 1'b0;

    // single requester 2
    set_angle(2, 32'h4000_0000);
    req_valid = 4'b0100;
    #1;
    chk("t2_ready", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    chk("t2_din_a", 64'(din_a), 64'h4000_0000);
    chk("t2_dvalid", 64'(din_valid), 1);
    chk("t2_outst", 64'(outstanding), 1);
    repeat (20) tick();
    chk("t2_early", 64'(rsp_valid), 0);
    tick();
    chk("t2_rspv", 64'(rsp_valid), 64'h4);
    chk("t2_cos", 64'(rsp_cos), 64'h4000_0001);
    chk("t2_sin", 64'(rsp_sin), 64'h4000_0002);
    chk("t2_outst0", 64'(outstanding), 0);

    // reset mid-traffic
    for (int i = 0; i < NR; i++) set_angle(i, ang[i]);
    req_valid = 4'hF;
    repeat (5) tick();
    RST = 1'b1;
    repeat (3) tick();
    chk("t1_ready", 64'(req_ready), 0);
    chk("t1_dvalid", 64'(din_valid), 0);
    chk("t1_outst", 64'(outstanding), 0);
    chk("t1_rspv", 64'(rsp_valid), 0);
    req_valid = '0;
    RST = 1'b0;
    r0 = rq.size();
    repeat (40) tick();
    chk("t1_no_rsp", 64'(rq.size() - r0), 0);
    chk("t1_err", 64'(err_orphan), 0);
    chk("t1_outst2", 64'(outstanding), 0);

    // all four valid for 16 cycles
    g0 = gq.size(); r0 = rq.size();
    req_valid = 4'hF;
    repeat (16) tick();
    req_valid = '0;
    chk("t3_outst", 64'(outstanding), 16);
    chk("t3_ngrant", 64'(gq.size() - g0), 16);
    for (int k = 0; k < 16; k++)
      if (g0 + k < gq.size())
        chk($sformatf("t3_grant%0d", k),
            64'(gq[g0+k]), 64'(k % 4));
    repeat (40) tick();
    chk("t3_nrsp", 64'(rq.size() - r0), 16);
    for (int k = 0; k < 16; k++)
      if (r0 + k < rq.size())
        chk($sformatf("t3_rsp%0d", k),
            {24'(rq[r0+k].idx), 8'h0, rq[r0+k].cos},
            {24'(k % 4), 8'h0, ang[k%4] + 32'd1});
    if (r0 < rq.size())
      chk("t3_sin0", 64'(rq[r0].sin), 64'(ang[0] + 32'd2));

    // saturate the tag FIFO with L=40
    lat = 40;
    g0 = gq.size(); r0 = rq.size();
    req_valid = 4'hF;
    repeat (41) tick();
    chk("t4_16iss", 64'(gq.size() - g0), 16);
    chk("t4_full_rdy", 64'(req_ready), 0);
    chk("t4_peak", 64'(outstanding), 16);
    tick();
    chk("t4_resume", 64'($countones(req_ready)), 1);
    chk("t4_outst15", 64'(outstanding), 15);
    repeat (29) tick();
    chk("t4_32iss", 64'(gq.size() - g0), 32);
    chk("t4_refull", 64'(outstanding), 16);
    req_valid = '0;
    repeat (45) tick();
    chk("t4_nrsp", 64'(rq.size() - r0), 32);
    chk("t4_drain", 64'(outstanding), 0);
    ne = 0;
    for (int k = 0; k < 32; k++)
      if (r0 + k >= rq.size() || g0 + k >= gq.size() ||
          rq[r0+k].idx != gq[g0+k]) ne++;
    chk("t4_order", 64'(ne), 0);
    chk("t4_viol", 64'(viol), 0);
    lat = 20;

    // orphan result
    r0 = rq.size();
    force_dv = 1'b1;
    tick();
    force_dv = 1'b0;
    chk("t5_err", 64'(err_orphan), 1);
    chk("t5_rspv", 64'(rsp_valid), 0);
    chk("t5_outst", 64'(outstanding), 0);
    repeat (3) tick();
    chk("t5_sticky", 64'(err_orphan), 1);
    chk("t5_no_rsp", 64'(rq.size() - r0), 0);

    // rfd low for 5 cycles during traffic
    g0 = gq.size(); r0 = rq.size();
    req_valid = 4'hF;
    repeat (4) tick();
    rfd = 1'b0;
    repeat (5) tick();
    rfd = 1'b1;
    repeat (4) tick();
    req_valid = '0;
    repeat (40) tick();
    chk("t6_ngrant", 64'(gq.size() - g0), 8);
    chk("t6_nrsp", 64'(rq.size() - r0), 8);
    ne = 0;
    for (int k = 0; k < 8; k++)
      if (r0 + k >= rq.size() || g0 + k >= gq.size() ||
          rq[r0+k].idx != gq[g0+k]) ne++;
    chk("t6_order", 64'(ne), 0);
    chk("t6_viol", 64'(viol), 0);
    chk("t6_err", 64'(err_orphan), 1);
    chk("t6_outst", 64'(outstanding), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
